// File: rtl/ifq_pkg.sv
// Shared types and helpers for the IF/ID instruction queue.
// The zero-latency bypass in if_id_queue is enabled by defining IFQ_BYPASS_EN.
package ifq_pkg;

   localparam int IFQ_XLEN = 32;
   localparam logic [IFQ_XLEN-1:0] NOP_INSTR = 32'h0;

   typedef struct packed {
      logic [IFQ_XLEN-1:0] instr;
      logic [IFQ_XLEN-1:0] pc_plus4;
   } ifq_entry_t;

   // Pointer width for a DEPTH-entry ring; never narrower than 1 bit.
   function automatic int ptr_width(input int depth);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << w) < depth) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/ifq_storage.sv
// Entry array for the IF/ID queue: one write port, one asynchronous read port.
// The data array is not reset; the queue's pointers and count decide what is valid.
module ifq_storage
   import ifq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  ifq_entry_t       wdata,
   input  logic [PW-1:0]    raddr,
   output ifq_entry_t       rdata
);

   ifq_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode, replacing the IF/ID register.
// Define IFQ_BYPASS_EN to let an empty queue pass InstrF straight to decode.
module if_id_queue
   import ifq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = IFQ_XLEN
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         InstrF,
   input  logic [WIDTH-1:0]         PCPlus4F,
   input  logic                     ValidF,
   input  logic                     StallD,
   input  logic                     FlushD,
   output logic [WIDTH-1:0]         InstrD,
   output logic [WIDTH-1:0]         PCPlus4D,
   output logic                     ValidD,
   output logic                     Full,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          stored_valid;
   logic          bypass;
   logic          push;
   logic          pop;
   ifq_entry_t    wdata;
   ifq_entry_t    rdata;

   assign stored_valid = (count != '0);
   assign Full         = (count == CNT_FULL);
   assign Count        = count;

`ifdef IFQ_BYPASS_EN
   // An empty queue with a consuming decode hands the fetch word straight through.
   assign bypass = ~stored_valid & ValidF & ~StallD & ~FlushD;
`else
   assign bypass = 1'b0;
`endif

   // A full queue refuses the push even if the head pops this cycle.
   assign push = ValidF & ~Full & ~FlushD & ~bypass;
   assign pop  = stored_valid & ~StallD & ~FlushD;

   assign wdata.instr    = InstrF;
   assign wdata.pc_plus4 = PCPlus4F;

   ifq_storage #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_storage (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (FlushD) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      ValidD   = stored_valid;
      InstrD   = NOP_INSTR;
      PCPlus4D = '0;
      if (stored_valid) begin
         InstrD   = rdata.instr;
         PCPlus4D = rdata.pc_plus4;
      end else if (bypass) begin
         ValidD   = 1'b1;
         InstrD   = InstrF;
         PCPlus4D = PCPlus4F;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst) begin
         assert (count <= CNT_FULL);
         assert (!(pop && count == '0));
      end
   end
`endif

endmodule
